// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: op codes, FSM states, serial
// frame geometry and the command bit-stream builder.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b100,
        ALU_SUB = 3'b101
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        WAIT_RX,
        RX,
        DONE
    } state_e;

    localparam int FRAME_LEN  = 11;
    localparam int CMD_FRAMES = 9;
    localparam int CMD_BITS   = FRAME_LEN * CMD_FRAMES;

    // One frame: start 0, type bit, 8 data bits MSB first, stop 1.
    function automatic logic [FRAME_LEN-1:0] make_frame(input logic is_ctl, input logic [7:0] data);
        return {1'b0, is_ctl, data, 1'b1};
    endfunction

    // Whole command, first transmitted bit in the MSB: B bytes, A bytes, ctl.
    function automatic logic [CMD_BITS-1:0] build_cmd_stream(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  op,
        input logic [3:0]  crc
    );
        return {make_frame(1'b0, b[31:24]), make_frame(1'b0, b[23:16]),
                make_frame(1'b0, b[15:8]),  make_frame(1'b0, b[7:0]),
                make_frame(1'b0, a[31:24]), make_frame(1'b0, a[23:16]),
                make_frame(1'b0, a[15:8]),  make_frame(1'b0, a[7:0]),
                make_frame(1'b1, {1'b0, op, crc})};
    endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Serial frame receiver: detects a start bit while enabled, then captures
// the type bit and 8 data bits (MSB first) and strobes on the stop bit.
module alu_frame_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       sout_i,
    output logic       start_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       type_o,
    output logic [7:0] byte_o
);

    logic       busy_q, busy_d;
    logic [3:0] cnt_q, cnt_d;
    logic       type_q, type_d;
    logic [7:0] shift_q, shift_d;

    assign start_o      = en_i && !busy_q && !sout_i;
    assign busy_o       = busy_q;
    // cnt 9 is the stop-bit cycle; type and data are complete by then.
    assign frame_done_o = busy_q && (cnt_q == 4'(FRAME_LEN - 2));
    assign type_o       = type_q;
    assign byte_o       = shift_q;

    // Next-state for the bit sampler.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        shift_d = shift_q;
        if (!en_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (cnt_q == 4'd0) begin
                type_d = sout_i;
            end else if (cnt_q <= 4'd8) begin
                shift_d = {shift_q[6:0], sout_i};
            end
            if (frame_done_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (!sout_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end
    end

    // Sampler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            type_q  <= 1'b0;
            shift_q <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester round-robin front end for a bit-serial ALU: sends a
// 9-frame command, collects the response and reports it to the requester.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int RSP_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    input  logic [1:0][2:0]  req_op,
    input  logic [1:0][3:0]  req_crc,
    output logic [1:0]       rsp_valid,
    output logic [31:0]      rsp_c,
    output logic [3:0]       rsp_flags,
    output logic [2:0]       rsp_crc,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic             sin,
    input  logic             sout
);

    localparam int             WCW       = $clog2(RSP_TIMEOUT + 1);
    // Counter holds "cycles since last stop bit"; at RSP_TIMEOUT-1 with no
    // start bit the next cycle is the timeout DONE.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(RSP_TIMEOUT - 1);
    localparam logic [6:0]     TX_LAST   = 7'(CMD_BITS - 1);

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic                grant_sel;
    logic [CMD_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [6:0]          tx_cnt_q, tx_cnt_d;
    logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [2:0]          rx_idx_q, rx_idx_d;
    logic [31:0]         c_acc_q, c_acc_d;
    logic [31:0]         rsp_c_q, rsp_c_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;
    logic [2:0]          rsp_crc_q, rsp_crc_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_to_q, rsp_to_d;

    logic                rx_en, rx_start, rx_busy, rx_done, rx_type;
    logic [7:0]          rx_byte;

    assign rx_en = (state_q == WAIT_RX) || (state_q == RX);

    alu_frame_rx u_frame_rx (
        .clk          (clk),
        .rst          (rst),
        .en_i         (rx_en),
        .sout_i       (sout),
        .start_o      (rx_start),
        .busy_o       (rx_busy),
        .frame_done_o (rx_done),
        .type_o       (rx_type),
        .byte_o       (rx_byte)
    );

    assign sin         = (state_q == TX) ? tx_shift_q[CMD_BITS-1] : 1'b1;
    assign rsp_c       = rsp_c_q;
    assign rsp_flags   = rsp_flags_q;
    assign rsp_crc     = rsp_crc_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;

    // FSM next-state, grant, TX shifting and response assembly.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        grant_sel   = 1'b0;
        tx_shift_d  = tx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        rx_idx_d    = rx_idx_q;
        c_acc_d     = c_acc_q;
        rsp_c_d     = rsp_c_q;
        rsp_flags_d = rsp_flags_q;
        rsp_crc_d   = rsp_crc_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_sel            = (&req_valid) ? ~last_q : req_valid[1];
                    req_ready[grant_sel] = 1'b1;
                    gnt_d                = grant_sel;
                    last_d               = grant_sel;
                    tx_shift_d           = build_cmd_stream(req_a[grant_sel], req_b[grant_sel],
                                                            req_op[grant_sel], req_crc[grant_sel]);
                    tx_cnt_d             = '0;
                    state_d              = TX;
                end
            end
            TX: begin
                tx_shift_d = {tx_shift_q[CMD_BITS-2:0], 1'b1};
                if (tx_cnt_q == TX_LAST) begin
                    wait_cnt_d = WCW'(1);
                    state_d    = WAIT_RX;
                end else begin
                    tx_cnt_d = tx_cnt_q + 7'd1;
                end
            end
            WAIT_RX: begin
                if (rx_start) begin
                    rx_idx_d = '0;
                    state_d  = RX;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_c_d     = '0;
                    rsp_flags_d = '0;
                    rsp_crc_d   = '0;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b1;
                    state_d     = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            RX: begin
                if (rx_done) begin
                    if (rx_idx_q == 3'd0 && rx_type) begin
                        rsp_c_d     = {24'h0, rx_byte};
                        rsp_flags_d = '0;
                        rsp_crc_d   = '0;
                        rsp_err_d   = 1'b1;
                        rsp_to_d    = 1'b0;
                        state_d     = DONE;
                    end else if (rx_idx_q == 3'd4) begin
                        rsp_c_d     = c_acc_q;
                        rsp_flags_d = rx_byte[6:3];
                        rsp_crc_d   = rx_byte[2:0];
                        rsp_err_d   = 1'b0;
                        rsp_to_d    = 1'b0;
                        state_d     = DONE;
                    end else begin
                        c_acc_d    = {c_acc_q[23:0], rx_byte};
                        rx_idx_d   = rx_idx_q + 3'd1;
                        wait_cnt_d = WCW'(1);
                    end
                end else if (!rx_busy && !rx_start) begin
                    // Idle gap between response frames shares the timeout.
                    if (wait_cnt_q == WAIT_LAST) begin
                        rsp_c_d     = '0;
                        rsp_flags_d = '0;
                        rsp_crc_d   = '0;
                        rsp_err_d   = 1'b0;
                        rsp_to_d    = 1'b1;
                        state_d     = DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
            end
            DONE: begin
                rsp_valid[gnt_q] = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; last_q=1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            tx_shift_q  <= '1;
            tx_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            rx_idx_q    <= '0;
            c_acc_q     <= '0;
            rsp_c_q     <= '0;
            rsp_flags_q <= '0;
            rsp_crc_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rx_idx_q    <= rx_idx_d;
            c_acc_q     <= c_acc_d;
            rsp_c_q     <= rsp_c_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_crc_q   <= rsp_crc_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: table of hand vectors, hand sequences for
// round-robin and mid-TX reset, then randomized transactions. A serial ALU
// responder answers on sout using plain arithmetic on the request operands.
module tb_alu_scheduler;

    localparam int TO = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid, req_ready, rsp_valid;
    logic [1:0][31:0] req_a, req_b;
    logic [1:0][2:0]  req_op;
    logic [1:0][3:0]  req_crc;
    logic [31:0]      rsp_c;
    logic [3:0]       rsp_flags;
    logic [2:0]       rsp_crc;
    logic             rsp_err, rsp_timeout, sin, sout;

    int checks    = 0;
    int failures  = 0;
    int last_gnt  = 1;
    int txn_no    = 0;
    int early_cnt = 0;

    logic [2:0] ops [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

    always #5 clk = ~clk;

    alu_scheduler #(.RSP_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .req_crc     (req_crc),
        .rsp_valid   (rsp_valid),
        .rsp_c       (rsp_c),
        .rsp_flags   (rsp_flags),
        .rsp_crc     (rsp_crc),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .sin         (sin),
        .sout        (sout)
    );

    typedef struct {
        logic [1:0]  vmask;
        int          exp_gnt;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [3:0]  crc;
        int          mode;      // 0 normal, 1 error packet, 2 silent
        logic [7:0]  err_byte;
        logic [3:0]  flags;
        logic [2:0]  rcrc;
        int          delay;
        int          gap;
        logic [31:0] exp_c;
    } vec_t;

    vec_t tbl [7];

    function automatic vec_t mk_vec(input logic [1:0] m, input int g, input logic [31:0] a, b,
                                    input logic [2:0] op, input logic [3:0] crc, input int mode,
                                    input logic [7:0] eb, input logic [3:0] fl, input logic [2:0] rc,
                                    input int dly, input int gap, input logic [31:0] exp_c);
        vec_t v;
        v.vmask = m; v.exp_gnt = g; v.a = a; v.b = b; v.op = op; v.crc = crc;
        v.mode = mode; v.err_byte = eb; v.flags = fl; v.rcrc = rc;
        v.delay = dly; v.gap = gap; v.exp_c = exp_c;
        return v;
    endfunction

    // Behavioural ALU.
    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b100:  return a + b;
            3'b101:  return a - b;
            default: return 32'h0;
        endcase
    endfunction

    // Expected sin stream; bit 98 is the first bit on the wire.
    function automatic logic [98:0] golden(input logic [31:0] a, b, input logic [2:0] op, input logic [3:0] crc);
        logic [7:0]  bytes [9];
        logic [98:0] s;
        int          p;
        for (int i = 0; i < 4; i++) begin
            bytes[i]     = b[31 - 8*i -: 8];
            bytes[4 + i] = a[31 - 8*i -: 8];
        end
        bytes[8] = {1'b0, op, crc};
        p = 98;
        for (int f = 0; f < 9; f++) begin
            s[p]     = 1'b0;
            s[p - 1] = (f == 8);
            for (int k = 0; k < 8; k++) s[p - 2 - k] = bytes[f][7 - k];
            s[p - 10] = 1'b1;
            p = p - 11;
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (txn %0d)", name, act, exp, txn_no);
        end
    endtask

    task automatic idle_cycle();
        if (rsp_valid != 2'b00) early_cnt++;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic is_ctl, input logic [7:0] data);
        logic [10:0] fr;
        fr = {1'b0, is_ctl, data, 1'b1};
        for (int i = 10; i >= 0; i--) begin
            sout = fr[i];
            if (rsp_valid != 2'b00) early_cnt++;
            @(negedge clk);
        end
        sout = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 2'b00; sout = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_gnt = 1;
    endtask

    // One full transaction: grant, command stream capture, response, report.
    task automatic run_vec(input vec_t v, input bit noise);
        logic [98:0] got, gold;
        logic [1:0]  oh;
        logic [31:0] c_val;
        int          bad_ready, g, o;
        g     = v.exp_gnt;
        o     = 1 - g;
        oh    = (g == 0) ? 2'b01 : 2'b10;
        gold  = golden(v.a, v.b, v.op, v.crc);
        c_val = alu_model(v.op, v.a, v.b);
        req_a[g] = v.a; req_b[g] = v.b; req_op[g] = v.op; req_crc[g] = v.crc;
        req_a[o] = ~v.a; req_b[o] = v.b ^ 32'h5a5a_0f0f; req_op[o] = ~v.op; req_crc[o] = ~v.crc;
        req_valid = v.vmask;
        #1;
        check("grant", 32'(req_ready), 32'(oh));
        @(negedge clk);
        check("ready_one_cycle", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        bad_ready = 0;
        for (int i = 0; i < 99; i++) begin
            got[98 - i] = sin;
            if (req_ready != 2'b00) bad_ready++;
            if (noise) req_valid = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        req_valid = 2'b00;
        checks++;
        if (got !== gold) begin
            failures++;
            $display("FAIL sin_stream: got %h, expected %h (txn %0d)", got, gold, txn_no);
        end
        check("ready_zero_in_tx", 32'(bad_ready), 32'h0);
        check("sin_idle_after_tx", 32'(sin), 32'h1);
        early_cnt = 0;
        if (v.mode == 2) begin
            for (int k = 1; k < TO; k++) idle_cycle();
        end else begin
            for (int k = 0; k < v.delay; k++) idle_cycle();
            if (v.mode == 1) begin
                send_frame(1'b1, v.err_byte);
            end else begin
                for (int f = 0; f < 4; f++) begin
                    if (f > 0) for (int k = 0; k < v.gap; k++) idle_cycle();
                    send_frame(1'b0, c_val[31 - 8*f -: 8]);
                end
                for (int k = 0; k < v.gap; k++) idle_cycle();
                send_frame(1'b1, {1'b0, v.flags, v.rcrc});
            end
        end
        check("no_early_rsp", 32'(early_cnt), 32'h0);
        check("rsp_valid", 32'(rsp_valid), 32'(oh));
        if (rsp_valid == 2'b00) begin
            for (int k = 0; k < 200 && rsp_valid == 2'b00; k++) @(negedge clk);
        end
        check("rsp_timeout", 32'(rsp_timeout), (v.mode == 2) ? 32'h1 : 32'h0);
        check("rsp_err", 32'(rsp_err), (v.mode == 1) ? 32'h1 : 32'h0);
        if (v.mode == 0) begin
            check("rsp_c", rsp_c, v.exp_c);
            check("rsp_flags", 32'(rsp_flags), 32'(v.flags));
            check("rsp_crc", 32'(rsp_crc), 32'(v.rcrc));
        end else if (v.mode == 1) begin
            check("rsp_c_err", rsp_c, v.exp_c);
        end
        $display("txn %0d gnt=%0d op=%0d a=%h b=%h mode=%0d rsp_c=%h flags=%h crc=%h err=%b to=%b",
                 txn_no, g, v.op, v.a, v.b, v.mode, rsp_c, rsp_flags, rsp_crc, rsp_err, rsp_timeout);
        @(negedge clk);
        check("rsp_valid_pulse", 32'(rsp_valid), 32'h0);
        check("hold_timeout", 32'(rsp_timeout), (v.mode == 2) ? 32'h1 : 32'h0);
        check("hold_err", 32'(rsp_err), (v.mode == 1) ? 32'h1 : 32'h0);
        if (v.mode != 2) check("hold_c", rsp_c, v.exp_c);
        last_gnt = g;
        txn_no++;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [98:0] gtmp;
        int          cnt;
        req_a = '0; req_b = '0; req_op = '0; req_crc = '0;
        rst = 1'b1; req_valid = 2'b00; sout = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_sin", 32'(sin), 32'h1);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_c", rsp_c, 32'h0);
        check("reset_rsp_flags", 32'(rsp_flags), 32'h0);
        check("reset_rsp_crc", 32'(rsp_crc), 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        check("reset_rsp_timeout", 32'(rsp_timeout), 32'h0);
        rst = 1'b0;
        last_gnt = 1;

        // Hand vectors with constant expected results.
        tbl[0] = mk_vec(2'b01, 0, 32'h1, 32'h2, 3'b100, 4'hA, 0, 8'h00, 4'h0, 3'h0, 3, 0, 32'h0000_0003);
        tbl[1] = mk_vec(2'b10, 1, 32'd10, 32'd3, 3'b101, 4'h3, 0, 8'h00, 4'h5, 3'h2, 0, 0, 32'h0000_0007);
        tbl[2] = mk_vec(2'b01, 0, 32'h5, 32'h6, 3'b100, 4'h1, 1, 8'hC9, 4'h0, 3'h0, 7, 0, 32'h0000_00C9);
        tbl[3] = mk_vec(2'b11, 1, 32'hF0F0_FFFF, 32'h0FF0_00FF, 3'b000, 4'h7, 0, 8'h00, 4'hF, 3'h7, 10, 5, 32'h00F0_00FF);
        tbl[4] = mk_vec(2'b01, 0, 32'h11, 32'h22, 3'b001, 4'h2, 2, 8'h00, 4'h0, 3'h0, 0, 0, 32'h0);
        tbl[5] = mk_vec(2'b11, 1, 32'h8000_0000, 32'h1, 3'b001, 4'h9, 0, 8'h00, 4'h9, 3'h1, 48, 2, 32'h8000_0001);
        tbl[6] = mk_vec(2'b10, 1, 32'h0, 32'h1, 3'b101, 4'hE, 0, 8'h00, 4'h0, 3'h4, 1, 1, 32'hFFFF_FFFF);
        for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b0);

        // Round-robin: both valid twice after reset -> req0 then req1.
        do_reset();
        run_vec(mk_vec(2'b11, 0, 32'hA5, 32'h5A, 3'b100, 4'h4, 0, 8'h00, 4'h2, 3'h3, 2, 0, 32'h0000_00FF), 1'b0);
        run_vec(mk_vec(2'b11, 1, 32'h100, 32'h1, 3'b101, 4'h6, 0, 8'h00, 4'h8, 3'h5, 4, 1, 32'h0000_00FF), 1'b0);

        // Reset in the middle of TX at bit 40.
        do_reset();
        req_a[0] = 32'h1234_5678; req_b[0] = 32'h9ABC_DEF0; req_op[0] = 3'b100; req_crc[0] = 4'hB;
        gtmp = golden(32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 4'hB);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (40) @(negedge clk);
        check("sin_bit40", 32'(sin), 32'(gtmp[58]));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_sin", 32'(sin), 32'h1);
        check("rst_mid_tx_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        last_gnt = 1;
        cnt = 0;
        for (int k = 0; k < 150; k++) begin
            if (rsp_valid != 2'b00 || sin != 1'b1) cnt++;
            @(negedge clk);
        end
        check("quiet_after_rst", 32'(cnt), 32'h0);
        run_vec(mk_vec(2'b01, 0, 32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 4'hB, 0, 8'h00, 4'h1, 3'h6, 5, 0, 32'hACF1_3568), 1'b0);

        // Randomized transactions against the behavioural model.
        for (int t = 0; t < 20; t++) begin
            logic [1:0]  m;
            logic [31:0] a, b;
            logic [2:0]  op;
            int          g, mode;
            m    = 2'($urandom_range(1, 3));
            g    = (m == 2'b11) ? (1 - last_gnt) : ((m == 2'b10) ? 1 : 0);
            a    = $urandom;
            b    = $urandom;
            op   = ops[$urandom_range(0, 3)];
            mode = ($urandom_range(0, 9) < 7) ? 0 : (($urandom_range(0, 1) == 1) ? 1 : 2);
            if (mode == 1) begin
                logic [7:0] eb;
                eb = 8'($urandom);
                run_vec(mk_vec(m, g, a, b, op, 4'($urandom), 1, eb, 4'h0, 3'h0,
                               $urandom_range(0, 48), 0, {24'h0, eb}), 1'b1);
            end else begin
                run_vec(mk_vec(m, g, a, b, op, 4'($urandom), mode, 8'h00, 4'($urandom), 3'($urandom),
                               $urandom_range(0, 48), $urandom_range(0, 6), alu_model(op, a, b)), 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
